// File: rtl/systolic_skew_buffer.sv
// Multi-lane skew/deskew delay line for the edges of a systolic array.
// Lane k is a chain of D(k) {valid,data} registers, where
//   SKEW_DIR=0: D(k) = BASE + STEP*k              (staircase skew in front of the PEs)
//   SKEW_DIR=1: D(k) = BASE + STEP*(LANES-1-k)    (deskew behind the PEs)
// All lanes advance together on en, flush together on clr, and outputs come straight
// from the last register of each chain.
module systolic_skew_buffer #(
    parameter int LANES      = 16,
    parameter int LANE_WIDTH = 16,
    parameter int BASE       = 1,
    parameter int STEP       = 1,
    parameter int SKEW_DIR   = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic [LANES*LANE_WIDTH-1:0] in_data,
    output logic [LANES-1:0]            out_valid,
    output logic [LANES*LANE_WIDTH-1:0] out_data,
    output logic                        busy
);

    // Per-lane "any valid in flight" flags, OR-reduced into busy.
    logic [LANES-1:0] lane_busy;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int DEPTH = (SKEW_DIR != 0) ? BASE + STEP * (LANES - 1 - k)
                                               : BASE + STEP * k;

        logic [DEPTH-1:0]      vld_q;
        logic [LANE_WIDTH-1:0] dat_q [DEPTH];
        logic [LANE_WIDTH-1:0] lane_in;

        assign lane_in = in_data[k*LANE_WIDTH +: LANE_WIDTH];

        // Shift chain: reset/flush clears every stage, en advances, otherwise hold.
        // Data is zeroed on entry when invalid, so every stage holds 0 whenever its
        // valid bit is 0 and the output needs no masking logic after the register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                // NOTE: the data stages are reset along with the valids (this is a
                // register chain, not a RAM), which is what guarantees out_data=0 while
                // out_valid=0 straight out of reset.
                for (int j = 0; j < DEPTH; j++) dat_q[j] <= '0;
            end else if (clr) begin
                vld_q <= '0;
                for (int j = 0; j < DEPTH; j++) dat_q[j] <= '0;
            end else if (en) begin
                // NOTE: non-blocking assignments make every stage sample the old value
                // of its predecessor, so the loop order does not matter.
                for (int j = DEPTH - 1; j >= 1; j--) begin
                    vld_q[j] <= vld_q[j-1];
                    dat_q[j] <= dat_q[j-1];
                end
                vld_q[0] <= in_valid;
                dat_q[0] <= in_valid ? lane_in : '0;
            end
        end

        assign out_valid[k]                          = vld_q[DEPTH-1];
        assign out_data[k*LANE_WIDTH +: LANE_WIDTH]  = dat_q[DEPTH-1];
        assign lane_busy[k]                          = |vld_q;
    end

    assign busy = |lane_busy;

endmodule
